// File: rtl/mma_pkg.sv
// Shared types and default dimensions for the systolic MAC array sequencer.
package mma_pkg;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int DRAIN_CYC = 2 * N - 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        READ,
        DONE
    } state_t;

    // Drain length for an arbitrary array size: read latency + skew + propagation.
    function automatic int drain_cyc(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/mma_seq_ctrl_if.sv
// Result-row handshake between the sequencer and the result collector.
interface mma_seq_ctrl_if #(
    parameter int N = 4
) ();

    localparam int AW = $clog2(N);

    // A row transfers on any rising edge where res_valid && res_ready; once raised,
    // res_valid and res_row hold stable until that transfer happens.
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_row;

    modport master(output res_valid, output res_row, input res_ready);
    modport slave(input res_valid, input res_row, output res_ready);

endinterface

// File: rtl/mma_skew.sv
// Diagonal skew for one array edge: lane i is the zero-gated input delayed by i cycles.
module mma_skew #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N*DW-1:0] in_vec,
    input  logic          in_valid,
    output logic [N*DW-1:0] out_vec
);

    logic [N*DW-1:0] gated;

    // Zeroing outside the operand window keeps buffer garbage off the array edges.
    assign gated = in_valid ? in_vec : '0;
    assign out_vec[DW-1:0] = gated[DW-1:0];

    for (genvar i = 1; i < N; i++) begin : g_lane
        logic [DW-1:0] sr_q [i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int d = 0; d < i; d++) sr_q[d] <= '0;
            end else begin
                sr_q[0] <= gated[i*DW +: DW];
                for (int d = 1; d < i; d++) sr_q[d] <= sr_q[d-1];
            end
        end

        assign out_vec[i*DW +: DW] = sr_q[i-1];
    end

endmodule

// File: rtl/mma_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array:
// clear, skewed operand feed, wavefront drain, then row-by-row result readout.
module mma_seq_ctrl
    import mma_pkg::*;
#(
    parameter int N  = mma_pkg::N,
    parameter int DW = mma_pkg::DW,
    parameter int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [N*DW-1:0] a_rd_data,
    input  logic [N*DW-1:0] b_rd_data,
    output logic            array_clr,
    output logic [N*DW-1:0] a_feed,
    output logic [N*DW-1:0] b_feed,
    mma_seq_ctrl_if.master  res,
    output state_t          dbg_state
);

    localparam int DRN_W = $clog2(2 * N);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(drain_cyc(N) - 1);
    localparam logic [AW-1:0]    LAST_IDX   = AW'(N - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic             clr_q;
    logic             res_valid_q;
    logic             dval_q;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    row_q;
    logic [DRN_W-1:0] drain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            dval_q      <= 1'b0;
            addr_q      <= '0;
            row_q       <= '0;
            drain_q     <= '0;
        end else begin
            // Buffer data lags the read enable by one cycle.
            dval_q <= rd_en_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= FEED;
                    clr_q   <= 1'b0;
                    rd_en_q <= 1'b1;
                    addr_q  <= '0;
                end
                FEED: begin
                    if (addr_q == LAST_IDX) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                        drain_q <= DRAIN_LAST;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q     <= READ;
                        res_valid_q <= 1'b1;
                        row_q       <= '0;
                    end else begin
                        drain_q <= drain_q - DRN_W'(1);
                    end
                end
                READ: begin
                    if (res.res_ready) begin
                        if (row_q == LAST_IDX) begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b0;
                            row_q       <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            row_q <= row_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mma_skew #(.N(N), .DW(DW)) u_skew_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vec  (a_rd_data),
        .in_valid(dval_q),
        .out_vec (a_feed)
    );

    mma_skew #(.N(N), .DW(DW)) u_skew_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vec  (b_rd_data),
        .in_valid(dval_q),
        .out_vec (b_feed)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign rd_en         = rd_en_q;
    assign rd_addr       = addr_q;
    assign array_clr     = clr_q;
    assign res.res_valid = res_valid_q;
    assign res.res_row   = row_q;
    assign dbg_state     = state_q;

endmodule
